spi_sample_capture: RTL and testbench

- Consumer of the sampling-rate counter's flag.
- On each rising edge of the tick input, runs one SPI mode-0 read of an external ADC and pushes the sample into a 2-entry output buffer drained over a val/rdy interface.
- Sits between the clock counter and the downstream DSP/packetizer.
- Reports dropped samples through a sticky overrun flag.

---
 rtl/spi_sample_capture_pkg.sv | 15 +
 rtl/sample_fifo2.sv | 68 ++++++
 rtl/spi_sample_capture.sv | 150 +++++++++++++++
 tb/tb_spi_sample_capture.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sample_capture_pkg.sv
// Shared types and constants for the SPI sample capture block.
package spi_sample_capture_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StShift,
        StCsHold,
        StPush
    } state_e;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned TS_BITS    = 16;

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry val/rdy FIFO; a push into a full buffer is accepted when a pop happens in the same cycle.
module sample_fifo2
    import spi_sample_capture_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_msg
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             full, push, pop;

    assign full    = (count_q == 2'(FIFO_DEPTH));
    assign out_val = (count_q != 2'd0);
    assign out_msg = out_val ? head_q : '0;
    assign pop     = out_val & out_rdy;
    assign in_rdy  = ~full | out_rdy;
    assign push    = in_val & in_rdy;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_msg;
                else                 tail_d = in_msg;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy stays the same; the new entry lands behind whatever remains.
                if (count_q == 2'd1) begin
                    head_d = in_msg;
                end else begin
                    head_d = tail_q;
                    tail_d = in_msg;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/spi_sample_capture.sv
// Runs one SPI mode-0 ADC read per rising tick and buffers samples for a val/rdy consumer.
// Optional SAMPLE_TIMESTAMP_EN adds a 16-bit tick timestamp carried with each sample.
module spi_sample_capture
    import spi_sample_capture_pkg::*;
#(
    parameter int unsigned NBITS   = 12,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_in,
    output logic               cs_n,
    output logic               sclk,
    input  logic               miso,
    output logic [NBITS-1:0]   recv_msg,
    output logic               recv_val,
    input  logic               recv_rdy,
    output logic               overrun,
    input  logic               overrun_clr
`ifdef SAMPLE_TIMESTAMP_EN
    ,
    output logic [TS_BITS-1:0] recv_ts
`endif
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
    localparam int unsigned BIT_W = $clog2(NBITS);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD  = BIT_W'(NBITS - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BIT_W-1:0] bit_q;
    logic [NBITS-1:0] shreg_q;
    logic             tick_q;
    logic             tick_rise, missed, push, fifo_rdy, drop;

    assign tick_rise = tick_in & ~tick_q;
    assign missed    = tick_rise & (state_q != StIdle);
    assign push      = (state_q == StPush);
    assign drop      = push & ~fifo_rdy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tick_q  <= 1'b0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            tick_q <= tick_in;
            // Set wins over a simultaneous clear.
            if (missed || drop)   overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (tick_rise) begin
                        state_q <= StCsSetup;
                        cs_n    <= 1'b0;
                        cnt_q   <= HALF_LOAD;
                    end
                end
                StCsSetup: begin
                    if (cnt_q == '0) begin
                        state_q <= StShift;
                        cnt_q   <= HALF_LOAD;
                        bit_q   <= BIT_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StShift: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        cnt_q <= HALF_LOAD;
                        if (!sclk) begin
                            sclk    <= 1'b1;
                            shreg_q <= {shreg_q[NBITS-2:0], miso};
                        end else begin
                            sclk <= 1'b0;
                            if (bit_q == '0) state_q <= StCsHold;
                            else             bit_q   <= bit_q - BIT_W'(1);
                        end
                    end
                end
                StCsHold: begin
                    if (cnt_q == '0) begin
                        cs_n    <= 1'b1;
                        state_q <= StPush;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StPush:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef SAMPLE_TIMESTAMP_EN
    logic [TS_BITS-1:0] ts_q, ts_lat_q;
    logic [TS_BITS+NBITS-1:0] fifo_out;

    // Only accepted ticks latch, so a missed tick cannot disturb the in-flight sample's stamp.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ts_q     <= '0;
            ts_lat_q <= '0;
        end else begin
            ts_q <= ts_q + TS_BITS'(1);
            if (tick_rise && state_q == StIdle) ts_lat_q <= ts_q;
        end
    end

    sample_fifo2 #(
        .WIDTH(TS_BITS + NBITS)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .in_val (push),
        .in_rdy (fifo_rdy),
        .in_msg ({ts_lat_q, shreg_q}),
        .out_val(recv_val),
        .out_rdy(recv_rdy),
        .out_msg(fifo_out)
    );

    assign recv_msg = fifo_out[NBITS-1:0];
    assign recv_ts  = fifo_out[TS_BITS+NBITS-1:NBITS];
`else
    sample_fifo2 #(
        .WIDTH(NBITS)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .in_val (push),
        .in_rdy (fifo_rdy),
        .in_msg (shreg_q),
        .out_val(recv_val),
        .out_rdy(recv_rdy),
        .out_msg(recv_msg)
    );
`endif

endmodule

// File: tb/tb_spi_sample_capture.sv
// Scoreboard bench for spi_sample_capture with a behavioural ADC and random tick traffic.
module tb_spi_sample_capture;

    localparam int unsigned NB  = 12;
    localparam int unsigned CD  = 2;
    localparam int          LAT = 2 * CD + 2 * NB * CD + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tick_in = 1'b0;
    logic          recv_rdy = 1'b0;
    logic          overrun_clr = 1'b0;
    logic          cs_n, sclk, miso, recv_val, overrun;
    logic [NB-1:0] recv_msg;
`ifdef SAMPLE_TIMESTAMP_EN
    logic [15:0]   recv_ts;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [NB-1:0] sb_q[$];
    logic [15:0]   sb_ts_q[$];
    logic [NB-1:0] adc_q[$];
    logic [NB-1:0] adc_word = '0;
    int            adc_idx = 0;
    logic [15:0]   ts_model = 16'd0;

    spi_sample_capture #(
        .NBITS  (NB),
        .CLK_DIV(CD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_in    (tick_in),
        .cs_n       (cs_n),
        .sclk       (sclk),
        .miso       (miso),
        .recv_msg   (recv_msg),
        .recv_val   (recv_val),
        .recv_rdy   (recv_rdy),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
`ifdef SAMPLE_TIMESTAMP_EN
        ,
        .recv_ts    (recv_ts)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        ts_model <= !reset ? 16'd0 : ts_model + 16'd1;
    end

    // ADC: MSB valid once selected, next bit presented on every sclk fall.
    assign miso = cs_n ? 1'b0 : adc_word[adc_idx];

    always @(negedge cs_n) begin
        if (adc_q.size() > 0) adc_word = adc_q.pop_front();
        else                  adc_word = '0;
        adc_idx = NB - 1;
    end

    always @(negedge sclk) begin
        if (!cs_n && adc_idx > 0) adc_idx = adc_idx - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [NB-1:0] w, input bit keep);
        adc_q.push_back(w);
        if (keep) begin
            sb_q.push_back(w);
            sb_ts_q.push_back(ts_model);
        end
    endtask

    // Monitor: every accepted handshake must match the oldest expected sample.
    always @(negedge clk) begin
        if (recv_val && recv_rdy) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sample: got 0x%0h expected none (cycle %0d)",
                         recv_msg, cyc);
            end else begin
                check("sample", 32'(recv_msg), 32'(sb_q.pop_front()));
`ifdef SAMPLE_TIMESTAMP_EN
                check("timestamp", 32'(recv_ts), 32'(sb_ts_q.pop_front()));
`else
                void'(sb_ts_q.pop_front());
`endif
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          rises, low_cnt, falls, last_acc, gap, pulse;
        logic        prev;
        bit          ign;
        logic [NB-1:0] w;

        // Reset state
        step(3);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_val", 32'(recv_val), 32'd0);
        check("rst_msg", 32'(recv_msg), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        step(2);

        // Single read with exact frame timing
        recv_rdy = 1'b1;
        issue(12'hA5C, 1'b1);
        tick_in = 1'b1;
        rises = 0;
        low_cnt = 0;
        prev = sclk;
        for (int c = 1; c <= 54; c++) begin
            step(1);
            tick_in = 1'b0;
            if (sclk && !prev) rises++;
            prev = sclk;
            if (!cs_n) low_cnt++;
            if (c == 1)  check("cs_fall", 32'(cs_n), 32'd0);
            if (c == 52) check("cs_last_low", 32'(cs_n), 32'd0);
            if (c == 53) check("cs_rise", 32'(cs_n), 32'd1);
            if (c == 53) check("val_early", 32'(recv_val), 32'd0);
            if (c == 54) check("val_latency", 32'(recv_val), 32'd1);
        end
        check("sclk_rises", 32'(rises), 32'd12);
        check("cs_low_cycles", 32'(low_cnt), 32'd52);
        check("single_overrun", 32'(overrun), 32'd0);
        step(5);

        // Held tick gives one transfer
        issue(NB'($urandom), 1'b1);
        tick_in = 1'b1;
        falls = 0;
        prev = cs_n;
        for (int c = 1; c <= 200; c++) begin
            step(1);
            if (prev && !cs_n) falls++;
            prev = cs_n;
        end
        tick_in = 1'b0;
        step(5);
        check("held_transfers", 32'(falls), 32'd1);
        check("held_overrun", 32'(overrun), 32'd0);

        // Tick during SHIFT is ignored and flagged
        issue(12'hA5C, 1'b1);
        tick_in = 1'b1;
        step(1);
        tick_in = 1'b0;
        step(19);
        tick_in = 1'b1;
        step(1);
        tick_in = 1'b0;
        check("busy_overrun_set", 32'(overrun), 32'd1);
        step(LAT);
        check("busy_overrun_sticky", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        check("busy_overrun_clr", 32'(overrun), 32'd0);

        // Backpressure: third sample dropped
        recv_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(NB'(i + 1), i < 2);
            tick_in = 1'b1;
            step(1);
            tick_in = 1'b0;
            step(59);
        end
        check("bp_overrun", 32'(overrun), 32'd1);
        check("bp_val", 32'(recv_val), 32'd1);
        check("bp_head", 32'(recv_msg), 32'h001);
        recv_rdy = 1'b1;
        step(4);
        check("bp_drained", 32'(recv_val), 32'd0);
        check("bp_empty_msg", 32'(recv_msg), 32'd0);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        check("bp_overrun_clr", 32'(overrun), 32'd0);

        // Reset mid-SHIFT aborts without a sample
        issue(NB'($urandom), 1'b0);
        tick_in = 1'b1;
        step(1);
        tick_in = 1'b0;
        step(29);
        reset = 1'b0;
        step(1);
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_val", 32'(recv_val), 32'd0);
        reset = 1'b1;
        step(3);
        issue(NB'($urandom), 1'b1);
        tick_in = 1'b1;
        step(1);
        tick_in = 1'b0;
        step(LAT + 5);
        check("abort_overrun", 32'(overrun), 32'd0);

        // Random tick traffic: a tick is accepted only once the previous frame is over
        last_acc = -100000;
        for (int n = 0; n < 24; n++) begin
            gap   = $urandom_range(20, 110);
            pulse = $urandom_range(1, 4);
            w     = NB'($urandom);
            ign   = 1'b0;
            for (int k = 0; k < gap; k++) begin
                if (k == 0) begin
                    if (cyc - last_acc >= LAT + 1) begin
                        last_acc = cyc;
                        issue(w, 1'b1);
                    end else begin
                        ign = 1'b1;
                    end
                end
                tick_in     = (k < pulse);
                overrun_clr = (k == 1) && ign;
                step(1);
                if (k == 0) check("rand_overrun", 32'(overrun), 32'(ign));
                if (k == 1 && ign) check("rand_overrun_clr", 32'(overrun), 32'd0);
            end
            overrun_clr = 1'b0;
        end
        tick_in = 1'b0;
        step(LAT + 10);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("adc_drained", 32'(adc_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
